// File: rtl/control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer feeding a 16-bit datapath.
// Optional conditional branch (opcode 0xC) enabled by defining TRON_BRANCH_EN.
module control_fsm #(
  parameter int              WIDTH    = 16,
  parameter int              REGBITS  = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        instr_in,
  input  logic               mem_ready,
  input  logic [4:0]         flags_in,
  output logic [WIDTH-1:0]   pc,
  output logic               addr_sel,
  output logic               mem_req,
  output logic               mem_write,
  output logic [REGBITS-1:0] reg_src_addr,
  output logic [REGBITS-1:0] reg_dst_addr,
  output logic [WIDTH-1:0]   immediate,
  output logic [3:0]         shift_amount,
  output logic [4:0]         alu_op,
  output logic [1:0]         shift_op,
  output logic [1:0]         bus_op,
  output logic               imm_mux,
  output logic               reg_write,
  output logic               halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [WIDTH-1:0] PC_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc_nxt;
  logic [15:0]      ir, ir_nxt;
  logic             run;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] imm_sext;
  logic             br_taken;

  assign opcode   = ir[15:12];
  assign imm_sext = {{(WIDTH-8){ir[7]}}, ir[7:0]};

`ifdef TRON_BRANCH_EN
  logic unused_flags;
  assign unused_flags = ^flags_in[2:0];

  // flags_in = {N,Z,F,L,C}
  always_comb begin
    br_taken = 1'b0;
    case (ir[11:8])
      4'h0:    br_taken = flags_in[3];
      4'h1:    br_taken = ~flags_in[3];
      4'h2:    br_taken = flags_in[4];
      4'hE:    br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end
`else
  logic unused_flags;
  assign unused_flags = ^flags_in;
  assign br_taken     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
      run   <= 1'b0;
    end else begin
      run <= 1'b1;
      if (run) begin
        state <= state_nxt;
        pc    <= pc_nxt;
        ir    <= ir_nxt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    addr_sel  = 1'b0;
    mem_req   = 1'b0;
    mem_write = 1'b0;
    bus_op    = 2'b00;
    imm_mux   = 1'b0;
    reg_write = 1'b0;
    halted    = 1'b0;
    if (run) begin
      unique case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_nxt    = instr_in;
            state_nxt = S_DECODE;
          end
        end
        S_DECODE: state_nxt = S_EXEC;
        S_EXEC: begin
          state_nxt = S_FETCH;
          pc_nxt    = pc + PC_ONE;
          case (opcode)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
              bus_op    = 2'b10;
              reg_write = 1'b1;
              imm_mux   = (opcode != 4'h0);
            end
            4'h8: begin
              bus_op    = 2'b11;
              reg_write = 1'b1;
            end
            4'h9, 4'hA: begin
              pc_nxt    = pc;
              state_nxt = S_MEM;
            end
            4'hC: if (br_taken) pc_nxt = pc + imm_sext;
            4'hF: begin
              halted    = 1'b1;
              pc_nxt    = pc;
              state_nxt = S_HALT;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          addr_sel  = 1'b1;
          mem_req   = 1'b1;
          mem_write = (opcode == 4'hA);
          if (mem_ready) begin
            if (opcode == 4'hA) begin
              pc_nxt    = pc + PC_ONE;
              state_nxt = S_FETCH;
            end else begin
              state_nxt = S_WB;
            end
          end
        end
        S_WB: begin
          bus_op    = 2'b01;
          reg_write = 1'b1;
          pc_nxt    = pc + PC_ONE;
          state_nxt = S_FETCH;
        end
        S_HALT:  halted = 1'b1;
        default: state_nxt = S_FETCH;
      endcase
    end
  end

  // IR field decodes are held at zero until the first edge after reset release
  assign reg_src_addr = run ? ir[REGBITS-1:0] : '0;
  assign reg_dst_addr = run ? ir[8 +: REGBITS] : '0;
  assign immediate    = run ? imm_sext : '0;
  assign shift_amount = run ? ir[3:0] : '0;
  assign shift_op     = run ? ir[5:4] : '0;
  assign alu_op       = !run ? 5'd0 :
                        (opcode == 4'h0) ? {1'b0, ir[7:4]} : {1'b1, opcode};

endmodule
